// File: rtl/bsg_manycore_store_responder.sv
// Remote-store target for non-processor manycore nodes. Buffers forward store
// packets, commits byte-masked data to a local word array and returns one
// packet per accepted store through its own return FIFO.
// Optional error counter: define BSG_MANYCORE_STORE_RESPONDER_ERR_CNT_EN.
module bsg_manycore_store_responder #(
    parameter int unsigned x_cord_width_p = 4,
    parameter int unsigned y_cord_width_p = 4,
    parameter int unsigned data_width_p   = 32,
    parameter int unsigned addr_width_p   = 32,
    parameter int unsigned mem_els_p      = 1024,
    parameter int unsigned in_fifo_els_p  = 4,
    parameter int unsigned ret_fifo_els_p = 4,
    localparam int unsigned packet_width_lp =
        6 + 2 * x_cord_width_p + 2 * y_cord_width_p + data_width_p + addr_width_p,
    localparam int unsigned ret_packet_width_lp = 5 + x_cord_width_p + y_cord_width_p,
    localparam int unsigned mem_addr_width_lp   = $clog2(mem_els_p)
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           v_i,
    input  logic [packet_width_lp-1:0]     data_i,
    output logic                           ready_o,
    output logic                           ret_v_o,
    output logic [ret_packet_width_lp-1:0] ret_data_o,
    input  logic                           ret_ready_i,
    input  logic                           r_v_i,
    input  logic [mem_addr_width_lp-1:0]   r_addr_i,
    output logic [data_width_p-1:0]        r_data_o,
    output logic [31:0]                    store_count_o,
    output logic [15:0]                    err_count_o
);

    localparam int unsigned CordW     = x_cord_width_p + y_cord_width_p;
    localparam int unsigned DataLsb   = 2 * CordW;
    localparam int unsigned AddrLsb   = DataLsb + data_width_p;
    localparam int unsigned OpLsb     = AddrLsb + addr_width_p;
    localparam int unsigned DataBytes = data_width_p / 8;
    localparam int unsigned InPtrW    = $clog2(in_fifo_els_p);
    localparam int unsigned InCntW    = $clog2(in_fifo_els_p + 1);
    localparam int unsigned RetPtrW   = $clog2(ret_fifo_els_p);
    localparam int unsigned RetCntW   = $clog2(ret_fifo_els_p + 1);

    localparam logic [addr_width_p-1:0] MemEls  = addr_width_p'(mem_els_p);
    localparam logic [InPtrW-1:0]       InLast  = InPtrW'(in_fifo_els_p - 1);
    localparam logic [RetPtrW-1:0]      RetLast = RetPtrW'(ret_fifo_els_p - 1);
    localparam logic [InCntW-1:0]       InFull  = InCntW'(in_fifo_els_p);
    localparam logic [RetCntW-1:0]      RetFull = RetCntW'(ret_fifo_els_p);

    // Input FIFO state
    logic [packet_width_lp-1:0] r_in_mem [in_fifo_els_p];
    logic [InPtrW-1:0]          r_in_wr_ptr, r_in_rd_ptr, w_in_wr_ptr_d, w_in_rd_ptr_d;
    logic [InCntW-1:0]          r_in_cnt, w_in_cnt_d;
    logic                       w_in_enq, w_in_deq;

    // Return FIFO state
    logic [ret_packet_width_lp-1:0] r_ret_mem [ret_fifo_els_p];
    logic [RetPtrW-1:0]             r_ret_wr_ptr, r_ret_rd_ptr, w_ret_wr_ptr_d, w_ret_rd_ptr_d;
    logic [RetCntW-1:0]             r_ret_cnt, w_ret_cnt_d;
    logic                           w_ret_enq, w_ret_deq, w_ret_full;

    // Head packet decode
    logic [packet_width_lp-1:0]   w_head;
    logic                         w_head_v;
    logic [5:0]                   w_op;
    logic [3:0]                   w_mask;
    logic [addr_width_p-1:0]      w_addr;
    logic [data_width_p-1:0]      w_data;
    logic [CordW-1:0]             w_from;
    logic                         w_is_store;
    logic                         w_store_deq;
    logic                         w_in_range;
    logic                         w_mem_we;
    logic [mem_addr_width_lp-1:0] w_mem_idx;
    logic                         w_unused_dest;

    logic [data_width_p-1:0] w_rd_word;
    logic [data_width_p-1:0] r_rdata;
    logic [31:0]             r_store_cnt;

    assign w_head   = r_in_mem[r_in_rd_ptr];
    assign w_head_v = (r_in_cnt != '0);
    assign w_op     = w_head[OpLsb +: 6];
    assign w_mask   = w_op[5:2];
    assign w_addr   = w_head[AddrLsb +: addr_width_p];
    assign w_data   = w_head[DataLsb +: data_width_p];
    assign w_from   = w_head[CordW +: CordW];
    // Destination coordinates already routed us here; nothing left to do with them.
    assign w_unused_dest = ^w_head[CordW-1:0];

    assign w_is_store = (w_op[1:0] == 2'b01);
    assign w_ret_full = (r_ret_cnt == RetFull);
    assign w_ret_deq  = ret_v_o & ret_ready_i;

    // Unknown ops never wait on the return FIFO; stores may use a slot freed this cycle.
    assign w_in_deq    = w_head_v & (~w_is_store | ~w_ret_full | w_ret_deq);
    assign w_store_deq = w_in_deq & w_is_store;
    assign w_in_enq    = v_i & ready_o;
    assign w_ret_enq   = w_store_deq;

    assign w_in_range = ((w_addr >> 2) < MemEls);
    assign w_mem_idx  = w_addr[2 +: mem_addr_width_lp];
    assign w_mem_we   = w_store_deq & w_in_range;

    assign ready_o       = (r_in_cnt != InFull);
    assign ret_v_o       = (r_ret_cnt != '0);
    assign ret_data_o    = r_ret_mem[r_ret_rd_ptr];
    assign r_data_o      = r_rdata;
    assign store_count_o = r_store_cnt;

    // Next-state for both FIFO pointer sets and occupancy counts
    always_comb begin
        w_in_wr_ptr_d  = r_in_wr_ptr;
        w_in_rd_ptr_d  = r_in_rd_ptr;
        w_ret_wr_ptr_d = r_ret_wr_ptr;
        w_ret_rd_ptr_d = r_ret_rd_ptr;
        if (w_in_enq)  w_in_wr_ptr_d  = (r_in_wr_ptr == InLast) ? '0 : r_in_wr_ptr + 1'b1;
        if (w_in_deq)  w_in_rd_ptr_d  = (r_in_rd_ptr == InLast) ? '0 : r_in_rd_ptr + 1'b1;
        if (w_ret_enq) w_ret_wr_ptr_d = (r_ret_wr_ptr == RetLast) ? '0 : r_ret_wr_ptr + 1'b1;
        if (w_ret_deq) w_ret_rd_ptr_d = (r_ret_rd_ptr == RetLast) ? '0 : r_ret_rd_ptr + 1'b1;
        w_in_cnt_d  = r_in_cnt + InCntW'(w_in_enq) - InCntW'(w_in_deq);
        w_ret_cnt_d = r_ret_cnt + RetCntW'(w_ret_enq) - RetCntW'(w_ret_deq);
    end

    // FIFO control registers; reset discards everything buffered
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_in_wr_ptr  <= '0;
            r_in_rd_ptr  <= '0;
            r_in_cnt     <= '0;
            r_ret_wr_ptr <= '0;
            r_ret_rd_ptr <= '0;
            r_ret_cnt    <= '0;
        end else begin
            r_in_wr_ptr  <= w_in_wr_ptr_d;
            r_in_rd_ptr  <= w_in_rd_ptr_d;
            r_in_cnt     <= w_in_cnt_d;
            r_ret_wr_ptr <= w_ret_wr_ptr_d;
            r_ret_rd_ptr <= w_ret_rd_ptr_d;
            r_ret_cnt    <= w_ret_cnt_d;
        end
    end

    // FIFO payload storage; validity is tracked by the counts above
    always_ff @(posedge clk_i) begin
        if (w_in_enq)  r_in_mem[r_in_wr_ptr]   <= data_i;
        if (w_ret_enq) r_ret_mem[r_ret_wr_ptr] <= {5'b0, w_from};
    end

    // Word array split into byte lanes; lanes past four reuse the mask cyclically
    for (genvar g = 0; g < DataBytes; g++) begin : g_byte
        logic [7:0] r_mem_b [mem_els_p];

        // Byte-lane write, not reset
        always_ff @(posedge clk_i) begin
            if (w_mem_we && w_mask[g % 4]) r_mem_b[w_mem_idx] <= w_data[8*g +: 8];
        end

        assign w_rd_word[8*g +: 8] = r_mem_b[r_addr_i];
    end

    // Local read port: captures pre-write data, holds when idle
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rdata <= '0;
        end else if (r_v_i) begin
            r_rdata <= w_rd_word;
        end
    end

    // Accepted-store counter, wraps; out-of-range stores count too
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_store_cnt <= '0;
        end else if (w_store_deq) begin
            r_store_cnt <= r_store_cnt + 32'd1;
        end
    end

`ifdef BSG_MANYCORE_STORE_RESPONDER_ERR_CNT_EN
    logic [15:0] r_err_cnt;
    logic        w_err_inc;

    assign w_err_inc   = w_in_deq & (~w_is_store | ~w_in_range);
    assign err_count_o = r_err_cnt;

    // Saturating error counter: out-of-range stores and unknown ops
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_err_cnt <= '0;
        end else if (w_err_inc && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end
`else
    assign err_count_o = '0;
`endif

endmodule

// File: tb/tb_bsg_manycore_store_responder.sv
// Randomized self-checking bench for bsg_manycore_store_responder with a
// transaction-level model: word array, return queue and counters.
module tb_bsg_manycore_store_responder;

    localparam int unsigned XW     = 4;
    localparam int unsigned YW     = 4;
    localparam int unsigned DW     = 32;
    localparam int unsigned AW     = 32;
    localparam int unsigned MemEls = 1024;
    localparam int unsigned InEls  = 4;
    localparam int unsigned RetEls = 4;
    localparam int unsigned PktW   = 6 + 2 * XW + 2 * YW + DW + AW;
    localparam int unsigned RetW   = 5 + XW + YW;
`ifdef BSG_MANYCORE_STORE_RESPONDER_ERR_CNT_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic            clk_i = 1'b0;
    logic            reset_n_i;
    logic            v_i;
    logic [PktW-1:0] data_i;
    logic            ready_o;
    logic            ret_v_o;
    logic [RetW-1:0] ret_data_o;
    logic            ret_ready_i;
    logic            r_v_i;
    logic [9:0]      r_addr_i;
    logic [31:0]     r_data_o;
    logic [31:0]     store_count_o;
    logic [15:0]     err_count_o;

    // ret_ready_i is either forced by the main flow or randomized per cycle
    logic rr_rand, rr_bit, rr_force;
    assign ret_ready_i = rr_rand ? rr_bit : rr_force;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model
    logic [31:0] mdl_mem [MemEls];
    logic [7:0]  exp_q [$];
    int unsigned mdl_stores = 0;
    int unsigned mdl_errs   = 0;
    int unsigned n_ret      = 0;

    bsg_manycore_store_responder #(
        .x_cord_width_p(XW),
        .y_cord_width_p(YW),
        .data_width_p  (DW),
        .addr_width_p  (AW),
        .mem_els_p     (MemEls),
        .in_fifo_els_p (InEls),
        .ret_fifo_els_p(RetEls)
    ) u_dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .v_i          (v_i),
        .data_i       (data_i),
        .ready_o      (ready_o),
        .ret_v_o      (ret_v_o),
        .ret_data_o   (ret_data_o),
        .ret_ready_i  (ret_ready_i),
        .r_v_i        (r_v_i),
        .r_addr_i     (r_addr_i),
        .r_data_o     (r_data_o),
        .store_count_o(store_count_o),
        .err_count_o  (err_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Apply one accepted packet to the model
    task automatic model_accept(input logic [5:0] op, input logic [31:0] addr,
                                input logic [31:0] data, input logic [7:0] from);
        logic [31:0] word;
        logic [31:0] bm;
        if (op[1:0] == 2'b01) begin
            exp_q.push_back(from);
            mdl_stores++;
            word = addr / 4;
            if (word < MemEls) begin
                bm = {{8{op[5]}}, {8{op[4]}}, {8{op[3]}}, {8{op[2]}}};
                mdl_mem[word[9:0]] = (mdl_mem[word[9:0]] & ~bm) | (data & bm);
            end else begin
                mdl_errs++;
            end
        end else begin
            mdl_errs++;
        end
    endtask

    // Drive one packet until it is accepted (bounded)
    task automatic send(input logic [5:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input logic [7:0] from);
        bit done = 1'b0;
        v_i    = 1'b1;
        data_i = {op, addr, data, from[7:4], from[3:0], 8'h00};
        for (int k = 0; k < 200 && !done; k++) begin
            if (ready_o) begin
                model_accept(op, addr, data, from);
                done = 1'b1;
            end
            @(posedge clk_i); #1;
        end
        v_i = 1'b0;
        if (!done) check_eq("send_timeout", ready_o, 1'b1);
    endtask

    // Let every expected return come out, then give the input FIFO time to empty
    task automatic drain();
        int k = 0;
        rr_rand  = 1'b0;
        rr_force = 1'b1;
        while (exp_q.size() != 0 && k < 500) begin
            @(posedge clk_i); #1;
            k++;
        end
        check_eq("drain", exp_q.size(), 0);
        repeat (InEls + 3) begin
            @(posedge clk_i); #1;
        end
    endtask

    task automatic read_chk(input string tag, input logic [9:0] a, input logic [31:0] exp);
        r_v_i    = 1'b1;
        r_addr_i = a;
        @(posedge clk_i); #1;
        r_v_i = 1'b0;
        check_eq(tag, r_data_o, exp);
    endtask

    task automatic check_counts(input string tag);
        int unsigned e;
        e = (mdl_errs > 32'hFFFF) ? 32'hFFFF : mdl_errs;
        check_eq({tag, "_stores"}, store_count_o, mdl_stores);
        check_eq({tag, "_errs"}, err_count_o, ErrEn ? e : 0);
    endtask

    // Return scoreboard: every handshake must match the oldest outstanding store
    always @(negedge clk_i) begin
        if (reset_n_i && ret_v_o && ret_ready_i) begin
            if (exp_q.size() == 0) begin
                check_eq("ret_spurious", ret_v_o, 1'b0);
            end else begin
                check_eq("ret_data", ret_data_o, {5'b0, exp_q.pop_front()});
                n_ret++;
            end
        end
    end

    initial begin
        rr_bit = 1'b1;
        forever begin
            @(posedge clk_i); #1;
            rr_bit = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old_v, new_v, rnd, hi, addr, data;
        logic [5:0]  op;
        logic [4:0]  w;
        int unsigned nr0, accepted;

        reset_n_i = 1'b0;
        v_i       = 1'b0;
        data_i    = '0;
        r_v_i     = 1'b0;
        r_addr_i  = '0;
        rr_rand   = 1'b0;
        rr_force  = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        @(posedge clk_i); #1;
        check_eq("rst_ready", ready_o, 1'b1);
        check_eq("rst_ret_v", ret_v_o, 1'b0);
        check_eq("rst_stores", store_count_o, 0);
        check_eq("rst_errs", err_count_o, 0);
        check_eq("rst_rdata", r_data_o, 0);

        // Full-word store and its two-cycle return latency
        send(6'b111101, 32'h10, 32'hDEADBEEF, 8'h12);
        check_eq("lat_n1_ret_v", ret_v_o, 1'b0);
        @(posedge clk_i); #1;
        check_eq("lat_n2_ret_v", ret_v_o, 1'b1);
        check_eq("lat_n2_ret_data", ret_data_o, 13'h012);
        drain();
        check_eq("full_stores", store_count_o, 1);
        read_chk("full_word4", 10'd4, 32'hDEADBEEF);

        // Byte-masked store over the same word
        send(6'b010001, 32'h10, 32'h11223344, 8'h12);
        drain();
        read_chk("mask_word4", 10'd4, mdl_mem[4]);

        // Give words 0..31 known contents
        for (int i = 0; i < 32; i++) begin
            send(6'b111101, 32'(i * 4), $urandom, 8'(i));
        end
        drain();
        check_counts("init");

        // Read and store to word 7 on the same edge
        old_v = mdl_mem[7];
        new_v = ~old_v;
        check_eq("coll_ready", ready_o, 1'b1);
        v_i    = 1'b1;
        data_i = {6'b111101, 32'h1C, new_v, 4'h0, 4'h7, 8'h00};
        model_accept(6'b111101, 32'h1C, new_v, 8'h07);
        @(posedge clk_i); #1;
        v_i      = 1'b0;
        r_v_i    = 1'b1;
        r_addr_i = 10'd7;
        @(posedge clk_i); #1;
        r_v_i = 1'b0;
        check_eq("coll_old", r_data_o, old_v);
        @(posedge clk_i); #1;
        check_eq("rdata_hold", r_data_o, old_v);
        read_chk("coll_new", 10'd7, mdl_mem[7]);
        drain();

        // Out-of-range store (aliases word 0) then an unknown op
        nr0 = n_ret;
        send(6'b111101, 32'(MemEls * 4), 32'hCAFEF00D, 8'h3C);
        drain();
        read_chk("oor_word0", 10'd0, mdl_mem[0]);
        check_counts("oor");
        send(6'b000010, 32'h20, 32'h0BADBEEF, 8'h45);
        drain();
        read_chk("unk_word8", 10'd8, mdl_mem[8]);
        check_counts("unk");
        check_eq("oor_unk_rets", n_ret - nr0, 1);

        // Backpressure: returns blocked, stream 12 stores
        nr0      = n_ret;
        accepted = 0;
        rr_force = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (ready_o && accepted < 12) begin
                data = $urandom;
                v_i    = 1'b1;
                data_i = {6'b111101, 32'((16 + accepted) * 4), data, 8'(8'h80 | accepted), 8'h00};
                model_accept(6'b111101, 32'((16 + accepted) * 4), data, 8'(8'h80 | accepted));
                accepted++;
            end else begin
                v_i = 1'b0;
            end
            @(posedge clk_i); #1;
        end
        v_i = 1'b0;
        check_eq("bp_ready_low", ready_o, 1'b0);
        check_eq("bp_accepted", accepted, InEls + RetEls);
        check_eq("bp_ret_v", ret_v_o, 1'b1);
        check_eq("bp_ret_hold", ret_data_o, {5'b0, exp_q[0]});
        rr_force = 1'b1;
        while (accepted < 12) begin
            send(6'b111101, 32'((16 + accepted) * 4), $urandom, 8'(8'h80 | accepted));
            accepted++;
        end
        drain();
        check_eq("bp_ret_total", n_ret - nr0, 12);
        check_counts("bp");

        // Random mix of masked, out-of-range and unknown ops with random return stalls
        rr_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rnd  = $urandom;
            data = $urandom;
            w    = rnd[30:26];
            if (rnd[25:22] == 4'd0) begin
                op = rnd[5:0];
                if (op[1:0] == 2'b01) op[1:0] = 2'b10;
                addr = $urandom;
            end else if (rnd[25:22] == 4'd1) begin
                op   = {rnd[5:2], 2'b01};
                hi   = 32'($urandom_range(1, 4000));
                addr = (hi << 12) | {25'b0, w, 2'b00};
            end else begin
                op   = {rnd[5:2], 2'b01};
                addr = {25'b0, w, rnd[1:0]};
            end
            send(op, addr, data, rnd[15:8]);
            if (rnd[20]) begin
                @(posedge clk_i); #1;
            end
        end
        drain();
        check_counts("rand");
        for (int i = 0; i < 32; i++) begin
            read_chk("rand_word", 10'(i), mdl_mem[i]);
        end

        // Reset with returns pending
        rr_force = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(6'b111101, 32'((40 + i) * 4), $urandom, 8'(8'h60 + i));
        end
        repeat (3) begin
            @(posedge clk_i); #1;
        end
        check_eq("pre_rst_ret_v", ret_v_o, 1'b1);
        check_eq("pre_rst_rdata", r_data_o, mdl_mem[31]);
        reset_n_i = 1'b0;
        #1;
        check_eq("mid_rst_ret_v", ret_v_o, 1'b0);
        check_eq("mid_rst_stores", store_count_o, 0);
        check_eq("mid_rst_errs", err_count_o, 0);
        check_eq("mid_rst_rdata", r_data_o, 0);
        exp_q.delete();
        mdl_stores = 0;
        mdl_errs   = 0;
        #2;
        reset_n_i = 1'b1;
        rr_force  = 1'b1;
        repeat (10) begin
            @(posedge clk_i); #1;
        end
        check_eq("post_rst_ret_v", ret_v_o, 1'b0);
        check_eq("post_rst_ready", ready_o, 1'b1);
        check_counts("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
